// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Queues coin/soda requests in saturating counters and sequences
//               one acknowledged actuator strobe at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int CNT_W   = 3,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    input  logic req2x2,
    input  logic req_soda,
    input  logic ack1,
    input  logic ack2,
    input  logic ack_vend,
    output logic eject1,
    output logic eject2,
    output logic vend,
    output logic busy,
    output logic ovf,
    output logic fault
);

    localparam int SUM_W  = CNT_W + 2;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GCNT_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GCNT_W-1:0] GAP_LAST = GCNT_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VEND  = 3'd1,
        S_EJ1   = 3'd2,
        S_EJ2   = 3'd3,
        S_GAP_W = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   p1_q, p1_d;
    logic [CNT_W-1:0]   p2_q, p2_d;
    logic [CNT_W-1:0]   ps_q, ps_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GCNT_W-1:0]  gap_q, gap_d;
    logic               ovf_q;
    logic               sat1, sat2, sats;
    logic               dec1, dec2, decs, ack_any;

    // Returns {saturated, next_value}; dec only fires on a nonzero counter.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] cur,
                                            input logic [1:0]       inc,
                                            input logic             dec);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cur) + SUM_W'(inc) - SUM_W'(dec);
        if (sum > SUM_W'(CNT_MAX)) begin
            return {1'b1, CNT_MAX};
        end
        return {1'b0, sum[CNT_W-1:0]};
    endfunction

    assign dec1    = (state_q == S_EJ1)  && ack1;
    assign dec2    = (state_q == S_EJ2)  && ack2;
    assign decs    = (state_q == S_VEND) && ack_vend;
    assign ack_any = dec1 || dec2 || decs;

    always_comb begin
        {sat1, p1_d} = bump(p1_q, {1'b0, req1}, dec1);
        {sat2, p2_d} = bump(p2_q, {req2x2, 1'b0} + {1'b0, req2}, dec2);
        {sats, ps_d} = bump(ps_q, {1'b0, req_soda}, decs);
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (ps_q != '0) begin
                    state_d = S_VEND;
                end else if (p2_q != '0) begin
                    state_d = S_EJ2;
                end else if (p1_q != '0) begin
                    state_d = S_EJ1;
                end
            end
            S_VEND, S_EJ1, S_EJ2: begin
                // An ack on the last allowed cycle still counts as completion.
                if (ack_any) begin
                    state_d = S_GAP_W;
                    gap_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_GAP_W: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            ps_q    <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            ps_q    <= ps_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            ovf_q   <= ovf_q | sat1 | sat2 | sats;
        end
    end

    // Strobes decode straight from the state so an async reset drops them at once.
    assign vend   = (state_q == S_VEND);
    assign eject1 = (state_q == S_EJ1);
    assign eject2 = (state_q == S_EJ2);
    assign fault  = (state_q == S_FAULT);
    assign ovf    = ovf_q;
    assign busy   = (p1_q != '0) || (p2_q != '0) || (ps_q != '0) || (state_q != S_IDLE);

endmodule
`default_nettype wire
